// File: rtl/ascon_perm_seq_pkg.sv
// Shared definitions for the Ascon permutation sequencer: command and
// state encodings, state geometry and the round-constant formula.
package ascon_perm_seq_pkg;

  // Ten 32-bit words make up the 320-bit state (lane L: lo=2L, hi=2L+1).
  localparam int NUM_WORDS = 10;
  localparam int NUM_LANES = 5;

  // The linear layer takes one word per cycle.
  localparam int LIN_STEPS = 10;

  // Rounds are numbered so that the last round is always index 11.
  localparam logic [3:0] ROUND_TOTAL = 4'd12;
  localparam logic [3:0] LAST_ROUND  = 4'd11;

  // Round constants are XORed into the lo word of lane 2.
  localparam int ADDC_WORD = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_PERM  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDC = 3'd1,
    ST_SBOX = 3'd2,
    ST_LIN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Round constant for round index i: 0xf0, 0xe1, ..., 0x4b.
  function automatic logic [31:0] round_const(input logic [3:0] i);
    return {24'h0, ~i, i};
  endfunction

endpackage

// File: rtl/ascon_perm_seq_sbox32.sv
// Bitsliced Ascon S-box over 32 bit positions. Purely combinational;
// the sequencer uses one instance for the lo words and one for the hi words.
module ascon_sbox32
  import ascon_perm_seq_pkg::*;
(
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [31:0] x3,
  input  logic [31:0] x4,
  output logic [31:0] y0,
  output logic [31:0] y1,
  output logic [31:0] y2,
  output logic [31:0] y3,
  output logic [31:0] y4
);

  logic [31:0] a0, a1, a2, a3, a4;
  logic [31:0] t0, t1, t2, t3, t4;

  // Input mixing, chi-like nonlinear step, output mixing and final inversion.
  always_comb begin
    a0 = x0;
    a1 = x1;
    a2 = x2;
    a3 = x3;
    a4 = x4;

    a0 = a0 ^ a4;
    a4 = a4 ^ a3;
    a2 = a2 ^ a1;

    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;

    a0 = a0 ^ t1;
    a1 = a1 ^ t2;
    a2 = a2 ^ t3;
    a3 = a3 ^ t4;
    a4 = a4 ^ t0;

    a1 = a1 ^ a0;
    a0 = a0 ^ a4;
    a3 = a3 ^ a2;
    a2 = ~a2;

    y0 = a0;
    y1 = a1;
    y2 = a2;
    y3 = a3;
    y4 = a4;
  end

endmodule

// File: rtl/ascon_perm_seq.sv
// Multi-cycle Ascon permutation sequencer. Owns the 320-bit state as ten
// 32-bit words and steps constant addition, S-box layer and a linear layer
// that is time-shared over an external sigma datapath one word per cycle.
module ascon_perm_seq
  import ascon_perm_seq_pkg::*;
#(
  parameter int MAX_ROUNDS = 12,
  parameter bit DONE_RSP   = 1'b1
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_idx,
  input  logic [3:0]  cmd_rounds,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        sig_lo,
  output logic        sig_hi,
  output logic [31:0] sig_rs1,
  output logic [31:0] sig_rs2,
  output logic [4:0]  sig_imm,
  input  logic [31:0] sig_rd
);

  localparam logic [3:0] MAX_R    = 4'(MAX_ROUNDS);
  localparam logic [3:0] IDX_LAST = 4'(NUM_WORDS - 1);
  localparam logic [3:0] LIN_LAST = 4'(LIN_STEPS - 1);

  state_e      state_reg, state_next;
  logic [3:0]  round_reg, round_next;
  logic [3:0]  step_reg, step_next;
  logic [31:0] temp_reg;
  logic [31:0] word_reg [NUM_WORDS];
  logic        rd_valid_reg;
  logic [31:0] rd_data_reg;

  op_e         op;
  logic        cmd_fire;
  logic        idx_ok;
  logic [3:0]  rounds_eff;
  logic [2:0]  lane;
  logic [3:0]  lo_idx;
  logic [3:0]  hi_idx;

  logic [31:0] lo_x [NUM_LANES];
  logic [31:0] hi_x [NUM_LANES];
  logic [31:0] lo_y [NUM_LANES];
  logic [31:0] hi_y [NUM_LANES];

  assign op         = op_e'(cmd_op);
  assign cmd_ready  = (state_reg == ST_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign idx_ok     = (cmd_idx <= IDX_LAST);
  assign rounds_eff = (cmd_rounds > MAX_R) ? MAX_R : cmd_rounds;
  assign busy       = (state_reg != ST_IDLE);

  // In LIN, step k works on lane k>>1; even steps do lo, odd steps do hi.
  assign lane   = step_reg[3:1];
  assign lo_idx = {lane, 1'b0};
  assign hi_idx = {lane, 1'b1};

  // Read responses are registered; a PERM completion is flagged while in DONE.
  assign rsp_valid = rd_valid_reg | (DONE_RSP && (state_reg == ST_DONE));
  assign rsp_rdata = rd_data_reg;

  // Gather the lo and hi halves of each lane for the two S-box slices.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lo_x[gi] = word_reg[2*gi];
      assign hi_x[gi] = word_reg[2*gi+1];
    end
  endgenerate

  ascon_sbox32 u_sbox_lo (
    .x0(lo_x[0]), .x1(lo_x[1]), .x2(lo_x[2]), .x3(lo_x[3]), .x4(lo_x[4]),
    .y0(lo_y[0]), .y1(lo_y[1]), .y2(lo_y[2]), .y3(lo_y[3]), .y4(lo_y[4])
  );

  ascon_sbox32 u_sbox_hi (
    .x0(hi_x[0]), .x1(hi_x[1]), .x2(hi_x[2]), .x3(hi_x[3]), .x4(hi_x[4]),
    .y0(hi_y[0]), .y1(hi_y[1]), .y2(hi_y[2]), .y3(hi_y[3]), .y4(hi_y[4])
  );

  // Sigma request: both lane words stay unmodified across the lo/hi pair.
  always_comb begin
    sig_lo  = 1'b0;
    sig_hi  = 1'b0;
    sig_rs1 = 32'h0;
    sig_rs2 = 32'h0;
    sig_imm = 5'h0;
    if (state_reg == ST_LIN) begin
      sig_lo  = ~step_reg[0];
      sig_hi  = step_reg[0];
      sig_rs1 = word_reg[lo_idx];
      sig_rs2 = word_reg[hi_idx];
      sig_imm = {2'b00, lane};
    end
  end

  // Next-state logic for the sequencer, round index and LIN step counter.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    step_next  = step_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire && (op == OP_PERM)) begin
          step_next = 4'd0;
          if (rounds_eff == 4'd0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ADDC;
            round_next = ROUND_TOTAL - rounds_eff;
          end
        end
      end
      ST_ADDC: state_next = ST_SBOX;
      ST_SBOX: begin
        state_next = ST_LIN;
        step_next  = 4'd0;
      end
      ST_LIN: begin
        if (step_reg == LIN_LAST) begin
          step_next = 4'd0;
          if (round_reg == LAST_ROUND) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ADDC;
            round_next = round_reg + 4'd1;
          end
        end else begin
          step_next = step_reg + 4'd1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequencer state, round index and step counter registers.
  always_ff @(posedge cop_clk or negedge cop_rst) begin
    if (!cop_rst) begin
      state_reg <= ST_IDLE;
      round_reg <= 4'd0;
      step_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
      step_reg  <= step_next;
    end
  end

  // State words: command writes, round constant, S-box layer and the
  // deferred lo write-back that lets the hi sigma op see the old lo word.
  always_ff @(posedge cop_clk or negedge cop_rst) begin
    if (!cop_rst) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        word_reg[w] <= 32'h0;
      end
      temp_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire && (op == OP_WRITE) && idx_ok) begin
            word_reg[cmd_idx] <= cmd_wdata;
          end
        end
        ST_ADDC: begin
          word_reg[ADDC_WORD] <= word_reg[ADDC_WORD] ^ round_const(round_reg);
        end
        ST_SBOX: begin
          for (int l = 0; l < NUM_LANES; l++) begin
            word_reg[2*l]   <= lo_y[l];
            word_reg[2*l+1] <= hi_y[l];
          end
        end
        ST_LIN: begin
          if (!step_reg[0]) begin
            temp_reg <= sig_rd;
          end else begin
            word_reg[hi_idx] <= sig_rd;
            word_reg[lo_idx] <= temp_reg;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered READ response; out-of-range indices return zero.
  always_ff @(posedge cop_clk or negedge cop_rst) begin
    if (!cop_rst) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= 32'h0;
    end else begin
      rd_valid_reg <= cmd_fire && (op == OP_READ);
      if (cmd_fire && (op == OP_READ) && idx_ok) begin
        rd_data_reg <= word_reg[cmd_idx];
      end else begin
        rd_data_reg <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Self-checking bench for ascon_perm_seq: a 64-bit-lane Ascon reference
// model and a sigma stub implementing the lane rotations.
module tb_ascon_perm_seq;

  logic        cop_clk = 1'b0;
  logic        cop_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_idx = 4'h0;
  logic [3:0]  cmd_rounds = 4'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic        sig_lo;
  logic        sig_hi;
  logic [31:0] sig_rs1;
  logic [31:0] sig_rs2;
  logic [4:0]  sig_imm;
  logic [31:0] sig_rd;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] mdl [5];
  logic [63:0] lin_full;

  localparam logic [4:0] SBOX_TBL [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  ascon_perm_seq dut (
    .cop_clk   (cop_clk),
    .cop_rst   (cop_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .cmd_rounds(cmd_rounds),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .sig_lo    (sig_lo),
    .sig_hi    (sig_hi),
    .sig_rs1   (sig_rs1),
    .sig_rs2   (sig_rs2),
    .sig_imm   (sig_imm),
    .sig_rd    (sig_rd)
  );

  always #5 cop_clk = ~cop_clk;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] lin_lane(input int lane, input logic [63:0] x);
    case (lane)
      0: return x ^ ror64(x, 19) ^ ror64(x, 28);
      1: return x ^ ror64(x, 61) ^ ror64(x, 39);
      2: return x ^ ror64(x, 1)  ^ ror64(x, 6);
      3: return x ^ ror64(x, 10) ^ ror64(x, 17);
      4: return x ^ ror64(x, 7)  ^ ror64(x, 41);
      default: return 64'h0;
    endcase
  endfunction

  // Sigma datapath stub: one 32-bit half of the lane's linear function.
  always_comb begin
    lin_full = lin_lane(int'(sig_imm), {sig_rs2, sig_rs1});
    sig_rd = 32'h0;
    if (sig_lo) sig_rd = lin_full[31:0];
    else if (sig_hi) sig_rd = lin_full[63:32];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int w);
    return w[0] ? mdl[w/2][63:32] : mdl[w/2][31:0];
  endfunction

  // Reference Ascon p^r on five 64-bit lanes.
  task automatic ref_perm(input int r);
    int r_eff;
    logic [63:0] y [5];
    logic [4:0] v, o;
    r_eff = (r > 12) ? 12 : r;
    for (int i = 12 - r_eff; i < 12; i++) begin
      mdl[2] = mdl[2] ^ 64'(((15 - i) << 4) | i);
      for (int b = 0; b < 64; b++) begin
        v = {mdl[0][b], mdl[1][b], mdl[2][b], mdl[3][b], mdl[4][b]};
        o = SBOX_TBL[v];
        y[0][b] = o[4];
        y[1][b] = o[3];
        y[2][b] = o[2];
        y[3][b] = o[1];
        y[4][b] = o[0];
      end
      for (int l = 0; l < 5; l++) mdl[l] = lin_lane(l, y[l]);
    end
  endtask

  task automatic do_write(input logic [3:0] idx, input logic [31:0] data);
    cmd_op = 2'b00;
    cmd_idx = idx;
    cmd_wdata = data;
    cmd_valid = 1'b1;
    @(negedge cop_clk);
    cmd_valid = 1'b0;
    if (idx < 4'd10) begin
      if (idx[0]) mdl[idx/2][63:32] = data;
      else mdl[idx/2][31:0] = data;
    end
  endtask

  task automatic do_read(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    cmd_op = 2'b01;
    cmd_idx = idx;
    cmd_valid = 1'b1;
    @(negedge cop_clk);
    cmd_valid = 1'b0;
    check_eq(tag, {rsp_valid, rsp_rdata}, {1'b1, exp});
  endtask

  // Back-to-back READ of all ten words against the model.
  task automatic read_all(input string tag);
    cmd_op = 2'b01;
    cmd_valid = 1'b1;
    for (int w = 0; w < 10; w++) begin
      cmd_idx = 4'(w);
      @(negedge cop_clk);
      check_eq($sformatf("%s_w%0d", tag, w), {rsp_valid, rsp_rdata}, {1'b1, mdl_word(w)});
    end
    cmd_valid = 1'b0;
  endtask

  task automatic write_random_state();
    for (int w = 0; w < 10; w++) do_write(4'(w), $urandom);
  endtask

  task automatic do_perm(input logic [3:0] r, input string tag);
    int n, r_eff, exp_cyc, lo_cnt, hi_cnt, bad, s;
    logic [31:0] held_rs1, held_rs2;
    r_eff = (r > 4'd12) ? 12 : int'(r);
    exp_cyc = (r_eff == 0) ? 1 : 12 * r_eff + 1;
    lo_cnt = 0; hi_cnt = 0; bad = 0; s = 0;
    held_rs1 = 32'h0; held_rs2 = 32'h0;
    cmd_op = 2'b10;
    cmd_rounds = r;
    cmd_valid = 1'b1;
    @(negedge cop_clk);
    cmd_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n <= 200) begin
      if (!busy || cmd_ready) bad++;
      if (sig_lo && sig_hi) bad++;
      if (sig_lo || sig_hi) begin
        if (sig_lo !== ((s % 2) == 0)) bad++;
        if (int'(sig_imm) != (s % 10) / 2) bad++;
        if (sig_lo) begin
          held_rs1 = sig_rs1;
          held_rs2 = sig_rs2;
          lo_cnt++;
        end else begin
          if (sig_rs1 !== held_rs1 || sig_rs2 !== held_rs2) bad++;
          hi_cnt++;
        end
        s++;
      end else if (sig_rs1 != 0 || sig_rs2 != 0 || sig_imm != 0) begin
        bad++;
      end
      @(negedge cop_clk);
      n++;
    end
    check_eq({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check_eq({tag, "_done_flags"}, {busy, cmd_ready, sig_lo, sig_hi}, 4'b1000);
    check_eq({tag, "_done_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_lo_cnt"}, 64'(lo_cnt), 64'(5 * r_eff));
    check_eq({tag, "_hi_cnt"}, 64'(hi_cnt), 64'(5 * r_eff));
    check_eq({tag, "_seq_err"}, 64'(bad), 0);
    @(negedge cop_clk);
    check_eq({tag, "_idle"}, {rsp_valid, busy, cmd_ready}, 3'b001);
    ref_perm(int'(r));
    $display("[TB] %s rounds=%0d cycles=%0d", tag, r, n);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [3:0] rr;
    for (int l = 0; l < 5; l++) mdl[l] = 64'h0;

    // Reset state
    repeat (3) @(negedge cop_clk);
    check_eq("rst_ctl", {rsp_valid, busy, sig_lo, sig_hi, sig_imm}, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    check_eq("rst_rs", {sig_rs2, sig_rs1}, 0);
    cop_rst = 1'b1;
    @(negedge cop_clk);
    check_eq("idle_ready_busy", {cmd_ready, busy}, 2'b10);
    read_all("rst_read");

    // Word access and index bounds
    do_write(4'd3, 32'hDEADBEEF);
    do_read("read_idx3", 4'd3, 32'hDEADBEEF);
    do_read("read_idx12", 4'd12, 32'h0);
    do_write(4'd15, 32'h12345678);
    read_all("after_w15");

    // Reserved op: accepted, no response, no effect
    cmd_op = 2'b11;
    cmd_valid = 1'b1;
    @(negedge cop_clk);
    cmd_valid = 1'b0;
    check_eq("rsvd_no_rsp", {rsp_valid, busy}, 2'b00);

    // Full permutation on words 0..9 = 0..9
    for (int w = 0; w < 10; w++) do_write(4'(w), 32'(w));
    do_perm(4'd12, "perm12");
    read_all("perm12_state");

    do_perm(4'd0, "perm0");
    read_all("perm0_state");

    do_perm(4'd15, "perm15");
    read_all("perm15_state");

    do_perm(4'd1, "perm1");
    read_all("perm1_state");

    // Reset in the middle of round 3, LIN step 5
    write_random_state();
    cmd_op = 2'b10;
    cmd_rounds = 4'd12;
    cmd_valid = 1'b1;
    @(negedge cop_clk);
    cmd_valid = 1'b0;
    repeat (43) @(negedge cop_clk);
    check_eq("mid_position", {sig_lo, sig_hi, sig_imm}, {1'b0, 1'b1, 5'd2});
    cop_rst = 1'b0;
    #1;
    check_eq("mid_rst_ctl", {rsp_valid, busy, sig_lo, sig_hi, sig_imm}, 0);
    check_eq("mid_rst_rdata", rsp_rdata, 0);
    check_eq("mid_rst_rs", {sig_rs2, sig_rs1}, 0);
    seen = 0;
    repeat (3) begin
      @(negedge cop_clk);
      if (rsp_valid) seen++;
    end
    cop_rst = 1'b1;
    repeat (2) begin
      @(negedge cop_clk);
      if (rsp_valid) seen++;
    end
    check_eq("mid_rst_no_rsp", 64'(seen), 0);
    for (int l = 0; l < 5; l++) mdl[l] = 64'h0;
    read_all("post_rst");
    write_random_state();
    do_perm(4'd12, "post_rst_perm");
    read_all("post_rst_perm_state");

    // Randomized state and round counts
    for (int it = 0; it < 6; it++) begin
      write_random_state();
      rr = 4'($urandom_range(0, 15));
      do_perm(rr, $sformatf("rand%0d", it));
      read_all($sformatf("rand%0d_state", it));
      do_read($sformatf("rand%0d_oob", it), 4'($urandom_range(10, 15)), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
